active_list_recovery_walker: RTL
================================

Name: active_list_recovery_walker

Overview:
- Sequences tail-side rollback of the active list after a misprediction or refetch, popping the flushed entries from the tail over several cycles.
- Arbitrates between the commit stage (head pops) and the rollback walk (tail pops).
- Emits per-cycle walk pointers so rename-logic recovery can restore mappings.
- Sits between the recovery manager, the commit stage and the active-list pointer logic.

Parameters:
ENTRY_NUM, 64, active list depth; need not be a power of 2.
WIDTH, 2, maximum entries popped per cycle, head or tail (commit width).
PTR_W, $clog2(ENTRY_NUM), pointer width.
CNT_W, $clog2(ENTRY_NUM+1), range-count width.
LANE_W, $clog2(WIDTH+1), per-cycle pop-count width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
startRecovery  in  1  one-cycle pulse that begins a rollback walk
flushHeadPtr  in  PTR_W  oldest flushed entry
flushTailPtr  in  PTR_W  current tail; one past the youngest entry
commitPopNum  in  LANE_W  head pops requested by commit
popHeadNum  out  LANE_W  head pops granted to the pointer logic
popTailNum  out  LANE_W  tail pops this cycle
walkValid  out  WIDTH  lane i pops an entry this cycle
walkPtr  out  WIDTH*PTR_W  lane i pointer = (curTail-1-i) mod ENTRY_NUM
remainingNum  out  CNT_W  entries still to pop
busy  out  1  FSM is not IDLE
commitStall  out  1  commit must hold off
recoveryDone  out  1  one-cycle pulse when the walk completes

Behaviour:
- Reset: state IDLE. All outputs 0. curTail and remainingNum are 0.
- FSM states: IDLE, WALK, DONE.
- Range on start: N = (flushTailPtr >= flushHeadPtr) ? flushTailPtr - flushHeadPtr : ENTRY_NUM + flushTailPtr - flushHeadPtr.
  - Computed at CNT_W bits.
  - Equal pointers mean N = 0; a full-list flush is not expressible.
- IDLE:
  - popHeadNum = commitPopNum; commitStall = 0.
  - On startRecovery: latch curTail = flushTailPtr and remainingNum = N.
  - Go to WALK if N > 0, else to DONE.
  - A commit pop in the same cycle as startRecovery is still granted; the flush range already excludes those entries.
- WALK:
  - pop = min(remainingNum, WIDTH); popTailNum = pop.
  - walkValid[i] = (i < pop); walkPtr lanes as defined above, wrapping below 0 by adding ENTRY_NUM.
  - Registered updates: remainingNum -= pop; curTail = (curTail - pop) mod ENTRY_NUM.
  - When remainingNum - pop == 0, go to DONE.
- DONE: recoveryDone = 1 for one cycle, then go to IDLE.
- In WALK and DONE: popHeadNum = 0, commitStall = 1, busy = 1.
- Latency:
  - startRecovery at cycle T gives the first tail pop at T+1.
  - Walk lasts ceil(N/WIDTH) cycles.
  - recoveryDone is asserted at T+1+ceil(N/WIDTH).
  - With N = 0, recoveryDone is asserted at T+1.
- startRecovery while busy is ignored. A simulation assertion fires on it.
- commitPopNum > WIDTH is illegal and caught by an assertion.
- rst at any point, including mid-walk, forces IDLE next cycle with all outputs 0. No partial state is retained.
- popTailNum and popHeadNum are never both nonzero in the same cycle.

Optional Feature:
- Macro: ACTIVE_LIST_WALK_STAT_EN.
- Defined: adds outputs walkCycleTotal (32 bit) and walkEntryTotal (32 bit).
  - Both are saturating counters, cleared by rst.
  - walkCycleTotal increments every cycle in WALK.
  - walkEntryTotal adds popTailNum every cycle.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Test Plan:
- ENTRY_NUM=64, WIDTH=2; start with head=10, tail=15 (N=5) -> popTailNum 2,2,1 on T+1..T+3; walkPtr {14,13},{12,11},{10}; recoveryDone at T+4; commitStall high T+1..T+4.
- Wrap: head=62, tail=1 (N=3) -> walkPtr {0,63} then {62}; remainingNum 3→1→0.
- head=tail=20 -> no tail pops, recoveryDone at T+1, back to IDLE at T+2.
- startRecovery with commitPopNum=2 at T -> popHeadNum=2 at T, popHeadNum=0 from T+1 until IDLE; second startRecovery mid-walk is ignored.
- rst asserted at T+2 of an N=8 walk -> T+3: IDLE, busy=0, popTailNum=0, remainingNum=0, no recoveryDone pulse.
- With ACTIVE_LIST_WALK_STAT_EN, two walks of N=5 and N=3 -> walkCycleTotal=5, walkEntryTotal=8.

Source files
------------

// File: rtl/active_list_recovery_walker_if.sv
`default_nettype none
// ============================================================================
// Module      : active_list_recovery_walker_if
// Description : Bundle of the recovery-walker control and status signals.
//               master = recovery manager / commit side (drives requests),
//               slave  = the walker itself.
//               Signals: startRecovery, flushHeadPtr, flushTailPtr,
//               commitPopNum (requests); popHeadNum, popTailNum, walkValid,
//               walkPtr, remainingNum, busy, commitStall, recoveryDone
//               (responses).
//               With ACTIVE_LIST_WALK_STAT_EN defined, walkCycleTotal and
//               walkEntryTotal are added as slave outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface active_list_recovery_walker_if #(
    parameter int ENTRY_NUM = 64,
    parameter int WIDTH     = 2,
    parameter int PTR_W     = $clog2(ENTRY_NUM),
    parameter int CNT_W     = $clog2(ENTRY_NUM + 1),
    parameter int LANE_W    = $clog2(WIDTH + 1)
);
    logic                   startRecovery;
    logic [PTR_W-1:0]       flushHeadPtr;
    logic [PTR_W-1:0]       flushTailPtr;
    logic [LANE_W-1:0]      commitPopNum;
    logic [LANE_W-1:0]      popHeadNum;
    logic [LANE_W-1:0]      popTailNum;
    logic [WIDTH-1:0]       walkValid;
    logic [WIDTH*PTR_W-1:0] walkPtr;
    logic [CNT_W-1:0]       remainingNum;
    logic                   busy;
    logic                   commitStall;
    logic                   recoveryDone;
`ifdef ACTIVE_LIST_WALK_STAT_EN
    logic [31:0]            walkCycleTotal;
    logic [31:0]            walkEntryTotal;

    modport master (
        output startRecovery, flushHeadPtr, flushTailPtr, commitPopNum,
        input  popHeadNum, popTailNum, walkValid, walkPtr, remainingNum,
               busy, commitStall, recoveryDone, walkCycleTotal, walkEntryTotal
    );
    modport slave (
        input  startRecovery, flushHeadPtr, flushTailPtr, commitPopNum,
        output popHeadNum, popTailNum, walkValid, walkPtr, remainingNum,
               busy, commitStall, recoveryDone, walkCycleTotal, walkEntryTotal
    );
`else
    modport master (
        output startRecovery, flushHeadPtr, flushTailPtr, commitPopNum,
        input  popHeadNum, popTailNum, walkValid, walkPtr, remainingNum,
               busy, commitStall, recoveryDone
    );
    modport slave (
        input  startRecovery, flushHeadPtr, flushTailPtr, commitPopNum,
        output popHeadNum, popTailNum, walkValid, walkPtr, remainingNum,
               busy, commitStall, recoveryDone
    );
`endif
endinterface
`default_nettype wire

// File: rtl/active_list_recovery_walker.sv
`default_nettype none
// ============================================================================
// Module      : active_list_recovery_walker
// Description : Rolls back the active list from the tail after a flush,
//               popping up to WIDTH entries per cycle, and arbitrates the
//               pointer logic between commit (head pops) and the walk
//               (tail pops). Per-lane walk pointers feed rename recovery.
// Ports       : clk, rst (sync, active high)
//               bus (slave modport of active_list_recovery_walker_if):
//                 startRecovery/flushHeadPtr/flushTailPtr  - walk request
//                 commitPopNum -> popHeadNum               - head-pop grant
//                 popTailNum/walkValid/walkPtr             - tail-pop lanes
//                 remainingNum/busy/commitStall/recoveryDone - status
// Option      : ACTIVE_LIST_WALK_STAT_EN adds saturating walkCycleTotal and
//               walkEntryTotal counters.
// Revision    : 1.0 - initial release
// ============================================================================
module active_list_recovery_walker #(
    parameter int ENTRY_NUM = 64,
    parameter int WIDTH     = 2,
    parameter int PTR_W     = $clog2(ENTRY_NUM),
    parameter int CNT_W     = $clog2(ENTRY_NUM + 1),
    parameter int LANE_W    = $clog2(WIDTH + 1)
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    active_list_recovery_walker_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_entry = CNT_W'(ENTRY_NUM);
    localparam logic [CNT_W-1:0] c_width = CNT_W'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WALK = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [PTR_W-1:0]   r_cur_tail;
    logic [CNT_W-1:0]   r_remaining;

    logic [CNT_W-1:0]   w_range;
    logic [CNT_W-1:0]   w_pop;
    logic [CNT_W-1:0]   w_tail_ext;
    logic [CNT_W-1:0]   w_next_tail;
    logic               w_walk;

    assign w_walk     = (r_state == S_WALK);
    assign w_tail_ext = CNT_W'(r_cur_tail);

    // Modular arithmetic below may wrap an intermediate at CNT_W bits; the
    // true result is always below ENTRY_NUM, so the final value is exact.
    always_comb begin
        w_range = '0;
        if (bus.flushTailPtr >= bus.flushHeadPtr)
            w_range = CNT_W'(bus.flushTailPtr) - CNT_W'(bus.flushHeadPtr);
        else
            w_range = c_entry + CNT_W'(bus.flushTailPtr) - CNT_W'(bus.flushHeadPtr);
    end

    always_comb begin
        w_pop = '0;
        if (w_walk)
            w_pop = (r_remaining < c_width) ? r_remaining : c_width;
    end

    always_comb begin
        w_next_tail = '0;
        if (w_tail_ext >= w_pop)
            w_next_tail = w_tail_ext - w_pop;
        else
            w_next_tail = w_tail_ext + c_entry - w_pop;
    end

    // Lane i walks youngest-first: (curTail - 1 - i) mod ENTRY_NUM.
    // Idle lanes drive zero so consumers never see stale pointers.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        logic [CNT_W-1:0] w_off;
        logic [CNT_W-1:0] w_lane_ptr;
        logic             w_lane_vld;

        assign w_off      = CNT_W'(i + 1);
        assign w_lane_ptr = (w_tail_ext >= w_off) ? (w_tail_ext - w_off)
                                                  : (w_tail_ext + c_entry - w_off);
        assign w_lane_vld = w_walk && (CNT_W'(i) < w_pop);

        assign bus.walkValid[i]               = w_lane_vld;
        assign bus.walkPtr[i*PTR_W +: PTR_W]  = w_lane_vld ? PTR_W'(w_lane_ptr) : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cur_tail  <= '0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.startRecovery) begin
                        r_cur_tail  <= bus.flushTailPtr;
                        r_remaining <= w_range;
                        r_state     <= (w_range != '0) ? S_WALK : S_DONE;
                    end
                end
                S_WALK: begin
                    r_remaining <= r_remaining - w_pop;
                    r_cur_tail  <= PTR_W'(w_next_tail);
                    if (r_remaining == w_pop)
                        r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Commit keeps the pointer logic only while idle; the head pop granted
    // in the start cycle is safe because the flush range excludes it.
    assign bus.popHeadNum   = (r_state == S_IDLE) ? bus.commitPopNum : '0;
    assign bus.popTailNum   = LANE_W'(w_pop);
    assign bus.remainingNum = r_remaining;
    assign bus.busy         = (r_state != S_IDLE);
    assign bus.commitStall  = (r_state != S_IDLE);
    assign bus.recoveryDone = (r_state == S_DONE);

`ifdef ACTIVE_LIST_WALK_STAT_EN
    logic [31:0] r_walk_cycles;
    logic [31:0] r_walk_entries;
    logic [32:0] w_entry_sum;

    assign w_entry_sum = {1'b0, r_walk_entries} + 33'(w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_walk_cycles  <= '0;
            r_walk_entries <= '0;
        end else begin
            if (w_walk && (r_walk_cycles != '1))
                r_walk_cycles <= r_walk_cycles + 32'd1;
            r_walk_entries <= w_entry_sum[32] ? '1 : w_entry_sum[31:0];
        end
    end

    assign bus.walkCycleTotal = r_walk_cycles;
    assign bus.walkEntryTotal = r_walk_entries;
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (bus.commitPopNum <= LANE_W'(WIDTH))
                else $error("commitPopNum %0d exceeds WIDTH", bus.commitPopNum);
            assert (!(bus.startRecovery && (r_state != S_IDLE)))
                else $warning("startRecovery while walker busy is ignored");
        end
    end
`endif

endmodule
`default_nettype wire
